if_fetch: RTL and testbench

Instruction-fetch stage of the TinyCPU pipeline, directly upstream of the IF/ID pipeline register. Owns the architectural fetch PC, drives the BaseRAM instruction port through a wait-state FSM, and holds each fetched word until ID accepts it. Yields the BaseRAM bus whenever MEM claims it, and applies branch/jump redirects from ID, discarding wrong-path words.

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/if_nextpc.sv | 23 ++
 rtl/if_fetch.sv | 115 +++++++++++
 tb/tb_if_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// reset PC, the NOP encoding used for an empty IF slot, and FSM states.
package if_fetch_pkg;

  localparam int unsigned RegW = 32;

  // Default fetch PC after reset.
  localparam logic [RegW-1:0] RESET_PC_DEF = 32'h8000_0000;

  // Encoding presented on if_inst_o while no word has been fetched.
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  // Width of the BaseRAM wait-state counter (SRAM_WAIT is 0..7).
  localparam int unsigned WaitW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  // Sequential next-instruction address; wraps modulo 2^32.
  function automatic logic [RegW-1:0] pc_plus4(input logic [RegW-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_nextpc.sv
// Combinational next-PC selection for the fetch stage.
// Priority: redirect target > sequential pc+4 on handoff > hold.
module if_nextpc
  import if_fetch_pkg::*;
(
  input  logic [RegW-1:0] i_pc,
  input  logic [RegW-1:0] i_target,
  input  logic            i_redirect,
  input  logic            i_handoff,
  output logic [RegW-1:0] o_next_pc
);

  // Select the PC to be fetched after this cycle.
  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect) begin
      o_next_pc = i_target;
    end else if (i_handoff) begin
      o_next_pc = pc_plus4(i_pc);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, reads BaseRAM through a
// wait-state FSM, holds the fetched word until ID accepts it, yields the
// bus to MEM on hazard, and applies ID redirects discarding wrong-path words.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [RegW-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned     SRAM_WAIT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ctl_id_allow_in_i,
  input  logic            ctl_jbr_taken_i,
  input  logic [RegW-1:0] jbr_target_i,
  input  logic            ctl_baseram_hazard_i,
  input  logic [31:0]     inst_sram_rdata_i,
  output logic [19:0]     inst_sram_addr_o,
  output logic            inst_sram_ce_n_o,
  output logic            inst_sram_oe_n_o,
  output logic [RegW-1:0] if_pc_o,
  output logic [31:0]     if_inst_o,
  output logic            ctl_if_over_o
);

  if (SRAM_WAIT > 7) begin : g_bad_wait
    $error("if_fetch: SRAM_WAIT must be in 0..7");
  end

  localparam logic [WaitW-1:0] WaitLast = WaitW'(SRAM_WAIT);

  fetch_state_e     r_state;
  logic [RegW-1:0]  r_pc;
  logic [WaitW-1:0] r_wait_cnt;
  logic [31:0]      r_inst;
  logic [RegW-1:0]  r_if_pc;

  logic             w_in_fetch;
  logic             w_if_over;
  logic             w_handoff;
  logic             w_wait_done;
  logic [RegW-1:0]  w_next_pc;

  assign w_in_fetch  = (r_state == ST_FETCH);
  assign w_wait_done = (r_wait_cnt == WaitLast);

  // A redirect in the same cycle withdraws the held word from ID.
  assign w_if_over = (r_state == ST_VALID) && !ctl_jbr_taken_i;
  assign w_handoff = w_if_over && ctl_id_allow_in_i;

  if_nextpc u_nextpc (
    .i_pc       (r_pc),
    .i_target   (jbr_target_i),
    .i_redirect (ctl_jbr_taken_i),
    .i_handoff  (w_handoff),
    .o_next_pc  (w_next_pc)
  );

  // Fetch FSM: wait-state counting, capture, hold, handoff and redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_wait_cnt <= '0;
      r_inst     <= INST_NOP;
      r_if_pc    <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
      if (ctl_jbr_taken_i) begin
        // Redirect overrides any capture, handoff or hazard this cycle.
        r_state    <= ST_FETCH;
        r_wait_cnt <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
          end
          ST_FETCH: begin
            if (ctl_baseram_hazard_i) begin
              // MEM took the bus; the access restarts from scratch.
              r_wait_cnt <= '0;
            end else if (w_wait_done) begin
              r_inst     <= inst_sram_rdata_i;
              r_if_pc    <= r_pc;
              r_wait_cnt <= '0;
              r_state    <= ST_VALID;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          ST_VALID: begin
            if (w_handoff) begin
              r_state    <= ST_FETCH;
              r_wait_cnt <= '0;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end
        endcase
      end
    end
  end

  // The bus is driven only while fetching and released the same cycle MEM claims it.
  assign inst_sram_ce_n_o = !w_in_fetch || ctl_baseram_hazard_i;
  assign inst_sram_oe_n_o = inst_sram_ce_n_o;
  assign inst_sram_addr_o = r_pc[21:2];

  assign if_pc_o       = r_if_pc;
  assign if_inst_o     = r_inst;
  assign ctl_if_over_o = w_if_over;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized
// run compared against a cycle-countdown reference model.
module tb_if_fetch;

  localparam int unsigned W     = 1;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rst, allow, jbr, haz;
  logic [31:0] target, rdata;
  logic [19:0] addr;
  logic        ce_n, oe_n, over;
  logic [31:0] if_pc, if_inst;

  int total = 0;
  int bad   = 0;

  // Reference model: phase flags plus remaining clean cycles before capture.
  bit          m_idle, m_fetch, m_valid;
  int unsigned m_left;
  logic [31:0] m_pc, m_hpc, m_hinst;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC), .SRAM_WAIT(W)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .ctl_id_allow_in_i    (allow),
    .ctl_jbr_taken_i      (jbr),
    .jbr_target_i         (target),
    .ctl_baseram_hazard_i (haz),
    .inst_sram_rdata_i    (rdata),
    .inst_sram_addr_o     (addr),
    .inst_sram_ce_n_o     (ce_n),
    .inst_sram_oe_n_o     (oe_n),
    .if_pc_o              (if_pc),
    .if_inst_o            (if_inst),
    .ctl_if_over_o        (over)
  );

  task automatic model_step();
    if (rst) begin
      m_idle = 1; m_fetch = 0; m_valid = 0; m_left = 0;
      m_pc = RPC; m_hpc = RPC; m_hinst = NOP;
    end else if (jbr) begin
      m_pc = target; m_idle = 0; m_fetch = 1; m_valid = 0; m_left = W + 1;
    end else if (m_idle) begin
      m_idle = 0; m_fetch = 1; m_left = W + 1;
    end else if (m_fetch) begin
      if (haz) m_left = W + 1;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hinst = rdata; m_hpc = m_pc; m_fetch = 0; m_valid = 1;
        end
      end
    end else if (m_valid && allow) begin
      m_pc = m_pc + 32'd4; m_valid = 0; m_fetch = 1; m_left = W + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; allow = 0; jbr = 0; haz = 0; target = '0; rdata = 32'h0280_0421;
    repeat (3) tick();
    rst = 0; #1;
    total++; if (ce_n !== 1'b1) begin bad++; $display("FAIL reset_ce_n got=%b want=1", ce_n); end
    total++; if (over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b want=0", over); end
    total++; if (if_inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", if_inst, NOP); end
    total++; if (if_pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h want=%h", if_pc, RPC); end
    for (int c = 1; c <= 2; c++) begin
      tick(); #1;
      total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL first_fetch_ce_n cyc=%0d got=%b want=0", c, ce_n); end
      total++; if (addr !== 20'h00000) begin bad++; $display("FAIL first_fetch_addr cyc=%0d got=%h want=00000", c, addr); end
    end
    tick(); #1;
    total++; if (over !== 1'b1) begin bad++; $display("FAIL first_word_over got=%b want=1", over); end
    total++; if (if_pc !== RPC) begin bad++; $display("FAIL first_word_pc got=%h want=%h", if_pc, RPC); end
    total++; if (if_inst !== 32'h0280_0421) begin bad++; $display("FAIL first_word_inst got=%h want=02800421", if_inst); end
  endtask

  task automatic test_backpressure();
    rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      allow = 0; #1;
      total++; if (over !== 1'b1) begin bad++; $display("FAIL bp_over cyc=%0d got=%b want=1", c, over); end
      total++; if (if_inst !== 32'h0280_0421) begin bad++; $display("FAIL bp_inst cyc=%0d got=%h want=02800421", c, if_inst); end
      total++; if (if_pc !== RPC) begin bad++; $display("FAIL bp_pc cyc=%0d got=%h want=%h", c, if_pc, RPC); end
      total++; if (ce_n !== 1'b1) begin bad++; $display("FAIL bp_ce_n cyc=%0d got=%b want=1", c, ce_n); end
      tick();
    end
    allow = 1; #1;
    total++; if (over !== 1'b1) begin bad++; $display("FAIL bp_release_over got=%b want=1", over); end
    tick();
    allow = 0; #1;
    total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL bp_next_ce_n got=%b want=0", ce_n); end
    total++; if (addr !== 20'h00001) begin bad++; $display("FAIL bp_next_addr got=%h want=00001", addr); end
  endtask

  task automatic test_hazard();
    rdata = 32'h1234_5678;
    tick();
    for (int c = 0; c < 2; c++) begin
      haz = 1; #1;
      total++; if (ce_n !== 1'b1) begin bad++; $display("FAIL haz_ce_n cyc=%0d got=%b want=1", c, ce_n); end
      total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL haz_oe_n cyc=%0d got=%b want=1", c, oe_n); end
      tick();
    end
    haz = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (over !== 1'b0) begin bad++; $display("FAIL haz_restart_over cyc=%0d got=%b want=0", c, over); end
      total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL haz_restart_ce_n cyc=%0d got=%b want=0", c, ce_n); end
      tick();
    end
    #1;
    total++; if (over !== 1'b1) begin bad++; $display("FAIL haz_valid_over got=%b want=1", over); end
    total++; if (if_pc !== 32'h8000_0004) begin bad++; $display("FAIL haz_valid_pc got=%h want=80000004", if_pc); end
    total++; if (if_inst !== 32'h1234_5678) begin bad++; $display("FAIL haz_valid_inst got=%h want=12345678", if_inst); end
  endtask

  task automatic test_redirect_handoff();
    jbr = 1; target = 32'h8000_0100; allow = 1; #1;
    total++; if (over !== 1'b0) begin bad++; $display("FAIL rdh_over got=%b want=0", over); end
    tick();
    jbr = 0; allow = 0; #1;
    total++; if (addr !== 20'h00040) begin bad++; $display("FAIL rdh_addr got=%h want=00040", addr); end
    total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL rdh_ce_n got=%b want=0", ce_n); end
    total++; if (over !== 1'b0) begin bad++; $display("FAIL rdh_fetch_over got=%b want=0", over); end
  endtask

  task automatic test_redirect_capture();
    rdata = 32'hCAFE_0001;
    tick();
    jbr = 1; target = 32'h8000_0200; #1;
    total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL rdc_cap_ce_n got=%b want=0", ce_n); end
    tick();
    jbr = 0; #1;
    total++; if (over !== 1'b0) begin bad++; $display("FAIL rdc_over got=%b want=0", over); end
    total++; if (addr !== 20'h00080) begin bad++; $display("FAIL rdc_addr got=%h want=00080", addr); end
    total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL rdc_ce_n got=%b want=0", ce_n); end
    total++; if (if_pc !== 32'h8000_0004) begin bad++; $display("FAIL rdc_dropped_pc got=%h want=80000004", if_pc); end
    total++; if (if_inst !== 32'h1234_5678) begin bad++; $display("FAIL rdc_dropped_inst got=%h want=12345678", if_inst); end
    tick(); tick(); #1;
    total++; if (over !== 1'b1) begin bad++; $display("FAIL rdc_target_over got=%b want=1", over); end
    total++; if (if_pc !== 32'h8000_0200) begin bad++; $display("FAIL rdc_target_pc got=%h want=80000200", if_pc); end
    total++; if (if_inst !== 32'hCAFE_0001) begin bad++; $display("FAIL rdc_target_inst got=%h want=cafe0001", if_inst); end
  endtask

  task automatic test_reset_midfetch();
    allow = 1; #1;
    tick();
    allow = 0; rst = 1; #1;
    total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL rmf_before_ce_n got=%b want=0", ce_n); end
    tick();
    rst = 0; #1;
    total++; if (ce_n !== 1'b1) begin bad++; $display("FAIL rmf_ce_n got=%b want=1", ce_n); end
    total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL rmf_oe_n got=%b want=1", oe_n); end
    total++; if (over !== 1'b0) begin bad++; $display("FAIL rmf_over got=%b want=0", over); end
    total++; if (if_inst !== NOP) begin bad++; $display("FAIL rmf_inst got=%h want=%h", if_inst, NOP); end
    total++; if (if_pc !== RPC) begin bad++; $display("FAIL rmf_pc got=%h want=%h", if_pc, RPC); end
    total++; if (addr !== 20'h00000) begin bad++; $display("FAIL rmf_addr got=%h want=00000", addr); end
  endtask

  task automatic test_wrap();
    jbr = 1; target = 32'hFFFF_FFFC; #1;
    tick();
    jbr = 0; #1;
    total++; if (addr !== 20'hFFFFF) begin bad++; $display("FAIL wrap_top_addr got=%h want=fffff", addr); end
    tick(); tick(); #1;
    total++; if (if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top_pc got=%h want=fffffffc", if_pc); end
    allow = 1; #1;
    tick();
    allow = 0; #1;
    total++; if (addr !== 20'h00000) begin bad++; $display("FAIL wrap_addr got=%h want=00000", addr); end
    tick(); tick(); #1;
    total++; if (over !== 1'b1) begin bad++; $display("FAIL wrap_over got=%b want=1", over); end
    total++; if (if_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc got=%h want=00000000", if_pc); end
  endtask

  task automatic test_random();
    logic e_over, e_ce_n;
    rst = 1; jbr = 0; haz = 0; allow = 0;
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      jbr    = ($urandom_range(0, 7) == 0);
      haz    = ($urandom_range(0, 3) == 0);
      allow  = ($urandom_range(0, 1) == 1);
      rdata  = $urandom;
      target = $urandom & 32'hFFFF_FFFC;
      #1;
      e_over = m_valid && !jbr;
      e_ce_n = !m_fetch || haz;
      total++; if (over !== e_over) begin bad++; $display("FAIL rnd_over cyc=%0d got=%b want=%b", c, over, e_over); end
      total++; if (ce_n !== e_ce_n) begin bad++; $display("FAIL rnd_ce_n cyc=%0d got=%b want=%b", c, ce_n, e_ce_n); end
      total++; if (oe_n !== e_ce_n) begin bad++; $display("FAIL rnd_oe_n cyc=%0d got=%b want=%b", c, oe_n, e_ce_n); end
      total++; if (addr !== m_pc[21:2]) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, addr, m_pc[21:2]); end
      total++; if (if_pc !== m_hpc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h want=%h", c, if_pc, m_hpc); end
      total++; if (if_inst !== m_hinst) begin bad++; $display("FAIL rnd_inst cyc=%0d got=%h want=%h", c, if_inst, m_hinst); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_hazard();
    test_redirect_handoff();
    test_redirect_capture();
    test_reset_midfetch();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
